// File: rtl/pulse_train_generator_pkg.sv
// rtl/pulse_train_generator_pkg.sv - shared types and helpers for the pulse train generator
//
// Purpose : state encoding for the train FSM and the zero-length rule helper.
// Ports   : none (package).

package pulse_train_generator_pkg;

  // Widest CNT_W the helper below supports; fields are zero-extended to this.
  localparam int MAX_CNT_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // A programmed phase length of 0 behaves as 1 cycle.
  function automatic logic [MAX_CNT_W-1:0] max1(input logic [MAX_CNT_W-1:0] value);
    logic [MAX_CNT_W-1:0] one;
    one = {{(MAX_CNT_W-1){1'b0}}, 1'b1};
    return (value == '0) ? one : value;
  endfunction

endpackage

// File: rtl/pulse_train_generator_phase_counter.sv
// rtl/pulse_train_generator_phase_counter.sv - loadable down-counter with zero flag for phase timing
//
// Purpose : times one HIGH or LOW phase. Loaded with (length-1); the phase
//           ends in the cycle where zero is seen.
// Ports   :
//   clock       in   system clock
//   reset_n     in   asynchronous active-low reset
//   load        in   load load_value this edge (takes priority over dec)
//   load_value  in   CNT_W value to load
//   dec         in   decrement this edge (saturates at 0)
//   zero        out  count is 0

module pulse_train_generator_phase_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pulse_train_generator.sv
// rtl/pulse_train_generator.sv - programmable train of N pulses, H cycles high, L cycles low between
//
// Purpose : on start, emits N pulses of max(H,1) high cycles separated by
//           max(L,1) low cycles, then a one-cycle done strobe. No gap follows
//           the last pulse. All outputs come straight from flops.
// Ports   :
//   clock        in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   start        in   request, sampled only while not busy
//   abort        in   ends an active train without done; beats start
//   pulse_count  in   CNT_W  number of pulses N (sampled with start)
//   high_cycles  in   CNT_W  high width H (sampled with start, 0 -> 1)
//   low_cycles   in   CNT_W  gap width L (sampled with start, 0 -> 1)
//   pulse_out    out  generated waveform
//   busy         out  train in progress
//   done         out  one-cycle strobe on normal completion

module pulse_train_generator
  import pulse_train_generator_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] pulse_count,
  input  logic [CNT_W-1:0] high_cycles,
  input  logic [CNT_W-1:0] low_cycles,
  output logic             pulse_out,
  output logic             busy,
  output logic             done
);

  state_t           state;
  state_t           state_next;

  // Latched phase reloads (length-1) and pulses still to be started.
  logic [CNT_W-1:0] high_m1;
  logic [CNT_W-1:0] low_m1;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] remaining_next;

  logic [CNT_W-1:0] high_m1_in;
  logic [CNT_W-1:0] low_m1_in;
  logic             accept;

  logic             pc_load;
  logic [CNT_W-1:0] pc_load_value;
  logic             pc_dec;
  logic             pc_zero;

  // max1() keeps the result >= 1, so subtracting 1 never wraps; an all-ones
  // field becomes all-ones minus one, i.e. the full 2^CNT_W-1 cycle phase.
  assign high_m1_in = CNT_W'(max1(MAX_CNT_W'(high_cycles))) - CNT_W'(1);
  assign low_m1_in  = CNT_W'(max1(MAX_CNT_W'(low_cycles)))  - CNT_W'(1);

  pulse_train_generator_phase_counter #(
    .CNT_W (CNT_W)
  ) u_phase_counter (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (pc_load),
    .load_value (pc_load_value),
    .dec        (pc_dec),
    .zero       (pc_zero)
  );

  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    pc_load        = 1'b0;
    pc_load_value  = '0;
    pc_dec         = 1'b0;
    accept         = 1'b0;

    unique case (state)
      // DONE accepts start exactly like IDLE so trains can run back to back.
      ST_IDLE, ST_DONE: begin
        state_next = ST_IDLE;
        if (start && !abort) begin
          accept = 1'b1;
          if (pulse_count == '0) begin
            state_next = ST_DONE;
          end else begin
            state_next     = ST_HIGH;
            pc_load        = 1'b1;
            pc_load_value  = high_m1_in;
            remaining_next = pulse_count - CNT_W'(1);
          end
        end
      end

      ST_HIGH: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (pc_zero) begin
          if (remaining == '0) begin
            state_next = ST_DONE;
          end else begin
            state_next    = ST_LOW;
            pc_load       = 1'b1;
            pc_load_value = low_m1;
          end
        end else begin
          pc_dec = 1'b1;
        end
      end

      ST_LOW: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (pc_zero) begin
          state_next     = ST_HIGH;
          pc_load        = 1'b1;
          pc_load_value  = high_m1;
          remaining_next = remaining - CNT_W'(1);
        end else begin
          pc_dec = 1'b1;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next-state decode so each is a plain flop.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      remaining <= '0;
      high_m1   <= '0;
      low_m1    <= '0;
      pulse_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      remaining <= remaining_next;
      if (accept) begin
        high_m1 <= high_m1_in;
        low_m1  <= low_m1_in;
      end
      pulse_out <= (state_next == ST_HIGH);
      busy      <= (state_next == ST_HIGH) || (state_next == ST_LOW);
      done      <= (state_next == ST_DONE);
    end
  end

endmodule

// File: tb/tb_pulse_train_generator.sv
// tb/tb_pulse_train_generator.sv - self-checking bench for pulse_train_generator

module tb_pulse_train_generator;

  localparam int CNT_W = 8;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [CNT_W-1:0] pulse_count = '0;
  logic [CNT_W-1:0] high_cycles = '0;
  logic [CNT_W-1:0] low_cycles = '0;
  logic             pulse_out;
  logic             busy;
  logic             done;

  int total = 0;
  int bad = 0;

  pulse_train_generator #(.CNT_W(CNT_W)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .abort       (abort),
    .pulse_count (pulse_count),
    .high_cycles (high_cycles),
    .low_cycles  (low_cycles),
    .pulse_out   (pulse_out),
    .busy        (busy),
    .done        (done)
  );

  always #5 clock = ~clock;

  typedef struct {
    int n;
    int h;
    int l;
    bit noise;
    int busy_len;
    int highs;
  } vec_t;

  vec_t tbl[8];

  task automatic check_bit(input string name, input logic actual, input logic expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s actual=%b required=%b", name, actual, expected);
    end
  endtask

  task automatic check_int(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic check_idle(input string name);
    check_bit({name, " pulse"}, pulse_out, 1'b0);
    check_bit({name, " busy"}, busy, 1'b0);
    check_bit({name, " done"}, done, 1'b0);
  endtask

  task automatic launch(input int n, input int h, input int l);
    start       = 1'b1;
    pulse_count = n[CNT_W-1:0];
    high_cycles = h[CNT_W-1:0];
    low_cycles  = l[CNT_W-1:0];
  endtask

  // Called at a negedge right after launch(). Builds the expected waveform from
  // the pulse/gap rule, compares every cycle and reports observed totals.
  task automatic run_train(input string tag, input int n, input int h, input int l,
                           input bit noise, input bit chain,
                           input int n2, input int h2, input int l2,
                           output int m_busy, output int m_high, output int m_rise,
                           output int m_fall, output int m_done);
    int   hp;
    int   lp;
    bit   ep[$];
    bit   eb[$];
    bit   ed[$];
    logic prev;
    hp = (h == 0) ? 1 : h;
    lp = (l == 0) ? 1 : l;
    for (int p = 0; p < n; p++) begin
      for (int c = 0; c < hp; c++) begin ep.push_back(1'b1); eb.push_back(1'b1); ed.push_back(1'b0); end
      if (p < n - 1)
        for (int c = 0; c < lp; c++) begin ep.push_back(1'b0); eb.push_back(1'b1); ed.push_back(1'b0); end
    end
    ep.push_back(1'b0); eb.push_back(1'b0); ed.push_back(1'b1);

    prev   = 1'b0;
    m_busy = 0; m_high = 0; m_rise = 0; m_fall = 0; m_done = 0;
    for (int i = 0; i < ep.size(); i++) begin
      @(negedge clock);
      if (chain && i == ep.size() - 1) begin
        launch(n2, h2, l2);
      end else begin
        start       = (noise && i < ep.size() - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        pulse_count = 8'($urandom);
        high_cycles = 8'($urandom);
        low_cycles  = 8'($urandom);
      end
      check_bit($sformatf("%s pulse[%0d]", tag, i), pulse_out, ep[i]);
      check_bit($sformatf("%s busy[%0d]", tag, i), busy, eb[i]);
      check_bit($sformatf("%s done[%0d]", tag, i), done, ed[i]);
      if (busy === 1'b1) m_busy++;
      if (pulse_out === 1'b1) m_high++;
      if (done === 1'b1) m_done++;
      if (pulse_out === 1'b1 && prev === 1'b0) m_rise++;
      if (pulse_out === 1'b0 && prev === 1'b1) m_fall++;
      prev = pulse_out;
    end
    if (!chain) begin
      @(negedge clock);
      start = 1'b0;
      check_idle({tag, " after"});
    end
  endtask

  task automatic check_edges(input string tag, input int n, input int rise, input int fall, input int dn);
    check_int({tag, " rising edges"}, rise, n);
    check_int({tag, " falling edges"}, fall, n);
    check_int({tag, " done strobes"}, dn, 1);
  endtask

  initial begin
    int mb, mh, mr, mf, md;
    int n, h, l;

    tbl[0] = '{n: 3, h: 2,   l: 1,   noise: 1'b0, busy_len: 8,   highs: 6};
    tbl[1] = '{n: 2, h: 0,   l: 0,   noise: 1'b0, busy_len: 3,   highs: 2};
    tbl[2] = '{n: 0, h: 5,   l: 5,   noise: 1'b0, busy_len: 0,   highs: 0};
    tbl[3] = '{n: 1, h: 255, l: 0,   noise: 1'b0, busy_len: 255, highs: 255};
    tbl[4] = '{n: 4, h: 1,   l: 3,   noise: 1'b1, busy_len: 13,  highs: 4};
    tbl[5] = '{n: 2, h: 255, l: 255, noise: 1'b0, busy_len: 765, highs: 510};
    tbl[6] = '{n: 5, h: 7,   l: 0,   noise: 1'b1, busy_len: 39,  highs: 35};
    tbl[7] = '{n: 255, h: 1, l: 1,   noise: 1'b1, busy_len: 509, highs: 255};

    repeat (3) @(negedge clock);
    check_idle("reset");
    reset_n = 1'b1;
    @(negedge clock);
    check_idle("post reset");

    foreach (tbl[k]) begin
      launch(tbl[k].n, tbl[k].h, tbl[k].l);
      run_train($sformatf("vec%0d", k), tbl[k].n, tbl[k].h, tbl[k].l, tbl[k].noise, 1'b0,
                0, 0, 0, mb, mh, mr, mf, md);
      check_int($sformatf("vec%0d busy cycles", k), mb, tbl[k].busy_len);
      check_int($sformatf("vec%0d high cycles", k), mh, tbl[k].highs);
      check_edges($sformatf("vec%0d", k), tbl[k].n, mr, mf, md);
    end

    // Back-to-back: new train requested in the DONE cycle of the previous one.
    launch(2, 1, 1);
    run_train("b2b first", 2, 1, 1, 1'b0, 1'b1, 3, 2, 2, mb, mh, mr, mf, md);
    check_edges("b2b first", 2, mr, mf, md);
    run_train("b2b second", 3, 2, 2, 1'b1, 1'b0, 0, 0, 0, mb, mh, mr, mf, md);
    check_int("b2b second high cycles", mh, 6);
    check_edges("b2b second", 3, mr, mf, md);

    // Abort in the first cycle of the 2nd HIGH phase (N=4, H=3, L=2).
    launch(4, 3, 2);
    for (int i = 0; i <= 5; i++) begin
      @(negedge clock);
      start = 1'b0;
    end
    check_bit("abort in 2nd high pulse", pulse_out, 1'b1);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check_idle("abort next cycle");
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check_idle($sformatf("abort settle%0d", i));
    end

    // abort together with start in IDLE: request is dropped.
    start = 1'b1; abort = 1'b1;
    pulse_count = 8'd3; high_cycles = 8'd1; low_cycles = 8'd1;
    @(negedge clock);
    start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_idle($sformatf("abort+start idle%0d", i));
      @(negedge clock);
    end

    // Asynchronous reset in the middle of a LOW gap.
    launch(3, 2, 4);
    for (int i = 0; i <= 2; i++) begin
      @(negedge clock);
      start = 1'b0;
    end
    check_bit("reset pre low pulse", pulse_out, 1'b0);
    check_bit("reset pre low busy", busy, 1'b1);
    #2 reset_n = 1'b0;
    #1 check_idle("async reset immediate");
    @(negedge clock);
    check_idle("async reset held");
    reset_n = 1'b1;
    launch(3, 2, 4);
    run_train("after reset", 3, 2, 4, 1'b0, 1'b0, 0, 0, 0, mb, mh, mr, mf, md);
    check_int("after reset busy cycles", mb, 14);
    check_edges("after reset", 3, mr, mf, md);

    // Randomized trains against the waveform model.
    for (int t = 0; t < 40; t++) begin
      n = $urandom_range(0, 6);
      h = $urandom_range(0, 6);
      l = $urandom_range(0, 6);
      launch(n, h, l);
      run_train($sformatf("rnd%0d", t), n, h, l, 1'($urandom_range(0, 1)), 1'b0,
                0, 0, 0, mb, mh, mr, mf, md);
      check_edges($sformatf("rnd%0d", t), n, mr, mf, md);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
